banco_reg_multi: RTL

Parametrised general-purpose register file for the datapath, succeeding the fixed 32×32 bank. It adds selectable width/depth, asynchronous active-low reset of every register, an optional hardwired zero register, and a valid/ready USART write port with a one-entry pending buffer so USART writes no longer collide with core writes. It also replaces the separately clocked output latch with a synchronous, edge-detected output capture.

---
 rtl/banco_reg_multi.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/banco_reg_multi.sv
// ---------------------------------------------------------------------------
// banco_reg_multi
// Parametrised general-purpose register file. It has two combinational read
// ports, a core write port, and a valid/ready USART write port. USART writes
// wait in a one-entry pending buffer and commit on a cycle when the core is
// not writing. An edge-detected output capture port is also provided.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width; depth = 2**ADDR_W
//   ZERO_REG  1: register 0 reads 0 and drops writes; 0: ordinary register
//
// Ports
//   clk_i, rst_n_i           system clock, async active-low reset
//   rd_addr_a_i/rd_data_a_o  read port A (combinational)
//   rd_addr_b_i/rd_data_b_o  read port B (combinational)
//   wr_en_i/wr_addr_i/wr_data_i            core write port (highest priority)
//   usart_valid_i/usart_ready_o/usart_addr_i/usart_data_i  USART write port
//   out_req_i/out_addr_i     capture request (rising edge) and address
//   out_data_o/out_valid_o   captured value and one-cycle update pulse
//
// Build option
//   BANCO_REG_BYPASS_EN  when defined, the read ports and the capture path
//                        forward this cycle's effective write (write-through).
// ---------------------------------------------------------------------------
module banco_reg_multi #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              usart_valid_i,
  output logic              usart_ready_o,
  input  logic [ADDR_W-1:0] usart_addr_i,
  input  logic [DATA_W-1:0] usart_data_i,
  input  logic              out_req_i,
  input  logic [ADDR_W-1:0] out_addr_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;

  logic              out_req_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_data;
  logic              eff_commit;
  logic              fwd_en;
  logic              usart_accept;
  logic              capture;
  logic [DATA_W-1:0] capture_val;

  // Core has priority; otherwise the pending USART entry drains.
  assign eff_we     = wr_en_i || pend_q;
  assign eff_addr   = wr_en_i ? wr_addr_i : pend_addr_q;
  assign eff_data   = wr_en_i ? wr_data_i : pend_data_q;
  // A write to the hardwired zero register still consumes the pending entry.
  assign eff_commit = eff_we && !(ZERO_REG && (eff_addr == '0));

`ifdef BANCO_REG_BYPASS_EN
  assign fwd_en = eff_commit;
`else
  assign fwd_en = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arr_val,
    input logic              fwd,
    input logic [ADDR_W-1:0] fwd_addr,
    input logic [DATA_W-1:0] fwd_data
  );
    if (ZERO_REG && (addr == '0)) return '0;
    if (fwd && (addr == fwd_addr)) return fwd_data;
    return arr_val;
  endfunction

  assign rd_data_a_o = read_sel(rd_addr_a_i, regs_q[rd_addr_a_i], fwd_en, eff_addr, eff_data);
  assign rd_data_b_o = read_sel(rd_addr_b_i, regs_q[rd_addr_b_i], fwd_en, eff_addr, eff_data);
  assign capture_val = read_sel(out_addr_i,  regs_q[out_addr_i],  fwd_en, eff_addr, eff_data);

  // The buffer can take a new entry when empty or when it drains this cycle.
  assign usart_ready_o = !pend_q || !wr_en_i;
  assign usart_accept  = usart_valid_i && usart_ready_o;

  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    if (!wr_en_i) begin
      pend_d = 1'b0;
    end
    if (usart_accept) begin
      pend_d      = 1'b1;
      pend_addr_d = usart_addr_i;
      pend_data_d = usart_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        regs_q[g] <= '0;
      end else if (eff_commit && (eff_addr == ADDR_W'(g))) begin
        regs_q[g] <= eff_data;
      end
    end
  end

  assign capture = out_req_i && !out_req_q;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = capture;
    if (capture) begin
      out_data_d = capture_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_req_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_req_q   <= out_req_i;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule
